smart_lane_input_buffer: RTL and testbench
==========================================

Name: smart_lane_input_buffer

Overview:
- Parametrised, multi-lane, credit-based flit input buffer for one router input port of the SMART mesh NoC.
- Each lane has its own FIFO of DEPTH flits of FLIT_WIDTH bits, valid/ready towards the crossbar, and a one-bit credit return towards the upstream router.
- New relative to the fixed single-lane buffering: configurable lane count/width/depth, optional low-load bypass when empty, per-lane enable with flush, occupancy reporting, sticky overflow detection.

Parameters:
- NUM_LANES, 1, number of independent lanes (≥1).
- FLIT_WIDTH, 33, bits per flit (matches FlitFixedData).
- DEPTH, 4, flit slots per lane FIFO (≥2, need not be power of two).
- BYPASS_ENABLE, 1, 1 = empty-FIFO flit may pass to output in the same cycle.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lane_enable  input  NUM_LANES  per-lane enable.
- flit_in  input  NUM_LANES×FLIT_WIDTH  incoming flit per lane.
- flit_in_valid  input  NUM_LANES  flit present this cycle.
- credit_out  output  NUM_LANES  one-cycle pulse = one slot freed (Credit type).
- flit_out  output  NUM_LANES×FLIT_WIDTH  head flit per lane.
- flit_out_valid  output  NUM_LANES  head flit valid.
- flit_out_ready  input  NUM_LANES  crossbar accepts head this cycle.
- occupancy  output  NUM_LANES×$clog2(DEPTH+1)  stored flit count.
- overflow_err  output  NUM_LANES  sticky: flit arrived with no free slot.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: all FIFOs empty; occupancy=0, credit_out=0, flit_out_valid=0, overflow_err=0, flit_out=0. Reset mid-operation discards stored flits. Upstream reinitialises to DEPTH credits after reset.
- Pop: occurs when flit_out_valid && flit_out_ready.
- Push: occurs when flit_in_valid && lane_enable && not bypassed.
  - Accepted if occupancy<DEPTH, or if occupancy==DEPTH and a pop occurs in the same cycle.
  - Otherwise the flit is dropped and overflow_err is set; it stays set until reset.
- Latency:
  - Stored path: a flit pushed at edge N is visible on flit_out after edge N (one cycle).
  - Bypass path (BYPASS_ENABLE=1): occupancy==0 && flit_in_valid && flit_out_ready && lane_enable drives flit_out=flit_in and flit_out_valid=1 combinationally; the flit is not stored (zero latency).
  - When bypass is disabled or flit_out_ready=0, the flit is pushed normally.
- flit_out_valid = lane_enable && (occupancy>0 || bypass condition).
- flit_out always shows the head entry when occupancy>0; it is undefined-but-stable when invalid.
- Credits: each pop (stored or bypassed) produces exactly one credit_out pulse, registered, in the cycle after the pop. Dropped flits produce no credit.
- Simultaneous push and pop: occupancy unchanged; pointers advance independently and wrap from DEPTH-1 to 0.
- Lane disable: while lane_enable=0, inputs are ignored (no push, no error) and flit_out_valid=0. At the first edge with lane_enable=0 the lane FIFO is flushed (occupancy→0) and no credits are returned for flushed entries. Upstream resets its credit count on re-enable.
- Lanes are fully independent; there is no cross-lane arbitration.
- occupancy is registered and reflects the state after the last edge.

Decomposition:
- Add to SMARTPkg:
  - localparam INPUT_BUFFER_DEPTH=4.
  - localparam INPUT_BUFFER_BYPASS=1.
  - typedef BufferCount = logic [$clog2(INPUT_BUFFER_DEPTH+1)-1:0].
  - Reuse Credit and FlitFixedData.
- Sub-module smart_flit_fifo:
  - Single lane: pointers, count, storage, bypass mux, credit register, flush, error flag.
  - Top instantiates NUM_LANES copies in a generate loop.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0; occupancy=0 every cycle.
- NUM_LANES=1, DEPTH=4, ready=0; push 0x1_0000_0001..0x1_0000_0004 -> occupancy 1,2,3,4. Raise ready for 4 cycles -> flits out in order; four credit_out pulses, each one cycle after its pop; occupancy=0.
- DEPTH=4 full, ready=0, push 0x0AA -> dropped, overflow_err=1 and stays 1, occupancy=4, no credit. Repeat with ready=1 on the same cycle -> accepted, occupancy stays 4, overflow_err unchanged from its prior value.
- Empty lane, BYPASS_ENABLE=1, ready=1, push 0x155 -> flit_out=0x155 and flit_out_valid=1 in the same cycle, occupancy stays 0, credit_out=1 next cycle. Same stimulus with BYPASS_ENABLE=0 -> output one cycle later.
- Push/pop every cycle for 20 cycles, DEPTH=3 (non-power-of-two wrap), incrementing data -> in-order output, no loss, occupancy constant, 20 credits.
- NUM_LANES=2: lane0 holds 3 flits; deassert lane_enable[0] one cycle -> lane0 occupancy=0, no credits, flit_out_valid[0]=0. Lane1 traffic continues unaffected. Assert rst_n=0 mid-traffic -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/smart_lane_input_buffer_pkg.sv
// Shared types and defaults for the SMART router input buffer.
// Credit and FlitFixedData match the router's existing link types.
package smart_lane_input_buffer_pkg;

  localparam int INPUT_BUFFER_DEPTH  = 4;
  localparam int INPUT_BUFFER_BYPASS = 1;

  typedef logic        Credit;
  typedef logic [32:0] FlitFixedData;
  typedef logic [$clog2(INPUT_BUFFER_DEPTH+1)-1:0] BufferCount;

endpackage

// File: rtl/smart_flit_fifo.sv
// Single-lane credit-returning flit FIFO with optional empty-bypass, flush on disable, sticky overflow.
// Latency: stored path 1 cycle, bypass path 0 cycles; credit pulse 1 cycle after each pop.
// Backpressure: head held while out_rdy=0; arrivals with no free slot are dropped and flagged.
module smart_flit_fifo
  import smart_lane_input_buffer_pkg::*;
#(
  parameter int FLIT_WIDTH    = $bits(FlitFixedData),
  parameter int DEPTH         = INPUT_BUFFER_DEPTH,
  parameter int BYPASS_ENABLE = INPUT_BUFFER_BYPASS,
  parameter int CW            = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [FLIT_WIDTH-1:0] in_dat,
  input  logic                  in_vld,
  input  logic                  out_rdy,
  output logic [FLIT_WIDTH-1:0] out_dat,
  output logic                  out_vld,
  output logic                  credit,
  output logic [CW-1:0]         occupancy,
  output logic                  overflow_err
);

  localparam int PW = $clog2(DEPTH);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  Credit                 credit_q;
  logic                  err_q;

  logic bypass, pop, pop_stored, push_try, push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    bypass     = (BYPASS_ENABLE != 0) && enable && (count == '0) && in_vld && out_rdy;
    out_vld    = enable && ((count != '0) || bypass);
    out_dat    = bypass ? in_dat : mem[rd_ptr];
    pop        = out_vld && out_rdy;
    pop_stored = pop && !bypass;
    push_try   = in_vld && enable && !bypass;
    // A full FIFO still accepts when the head leaves on the same edge.
    push_ok    = push_try && ((count < CW'(DEPTH)) || pop_stored);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!enable) begin
      // Flushed entries return no credit; upstream re-seeds on re-enable.
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      credit_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_stored) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_stored})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      credit_q <= pop;
      err_q    <= err_q | (push_try && !push_ok);
    end
  end

  assign credit       = credit_q;
  assign occupancy    = count;
  assign overflow_err = err_q;

endmodule

// File: rtl/smart_lane_input_buffer.sv
// Multi-lane router input buffer: one independent smart_flit_fifo per lane, no cross-lane arbitration.
// Latency: 1 cycle stored, 0 cycles on empty bypass; credit returned 1 cycle after each pop.
// Backpressure: per-lane flit_out_ready holds the head; upstream is credit-limited, overruns are flagged.
module smart_lane_input_buffer
  import smart_lane_input_buffer_pkg::*;
#(
  parameter int NUM_LANES     = 1,
  parameter int FLIT_WIDTH    = $bits(FlitFixedData),
  parameter int DEPTH         = INPUT_BUFFER_DEPTH,
  parameter int BYPASS_ENABLE = INPUT_BUFFER_BYPASS,
  parameter int CW            = $clog2(DEPTH+1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_LANES-1:0]            lane_enable,
  input  logic [NUM_LANES*FLIT_WIDTH-1:0] flit_in,
  input  logic [NUM_LANES-1:0]            flit_in_valid,
  output logic [NUM_LANES-1:0]            credit_out,
  output logic [NUM_LANES*FLIT_WIDTH-1:0] flit_out,
  output logic [NUM_LANES-1:0]            flit_out_valid,
  input  logic [NUM_LANES-1:0]            flit_out_ready,
  output logic [NUM_LANES*CW-1:0]         occupancy,
  output logic [NUM_LANES-1:0]            overflow_err
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    smart_flit_fifo #(
      .FLIT_WIDTH    (FLIT_WIDTH),
      .DEPTH         (DEPTH),
      .BYPASS_ENABLE (BYPASS_ENABLE),
      .CW            (CW)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (lane_enable[l]),
      .in_dat       (flit_in[l*FLIT_WIDTH +: FLIT_WIDTH]),
      .in_vld       (flit_in_valid[l]),
      .out_rdy      (flit_out_ready[l]),
      .out_dat      (flit_out[l*FLIT_WIDTH +: FLIT_WIDTH]),
      .out_vld      (flit_out_valid[l]),
      .credit       (credit_out[l]),
      .occupancy    (occupancy[l*CW +: CW]),
      .overflow_err (overflow_err[l])
    );
  end

endmodule

// File: tb/tb_smart_lane_input_buffer.sv
// Directed bench: dut_a = 2 lanes, DEPTH 4, bypass on; dut_b = 1 lane, DEPTH 3, bypass off.
module tb_smart_lane_input_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  a_en, a_iv, a_rdy, a_cr, a_ov, a_err;
  logic [65:0] a_in, a_out;
  logic [5:0]  a_occ;

  logic        b_en, b_iv, b_rdy, b_cr, b_ov, b_err;
  logic [32:0] b_in, b_out;
  logic [1:0]  b_occ;

  int total = 0;
  int bad   = 0;
  int b_credits;

  smart_lane_input_buffer #(.NUM_LANES(2), .FLIT_WIDTH(33), .DEPTH(4), .BYPASS_ENABLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .lane_enable(a_en), .flit_in(a_in), .flit_in_valid(a_iv),
    .credit_out(a_cr), .flit_out(a_out), .flit_out_valid(a_ov), .flit_out_ready(a_rdy),
    .occupancy(a_occ), .overflow_err(a_err)
  );

  smart_lane_input_buffer #(.NUM_LANES(1), .FLIT_WIDTH(33), .DEPTH(3), .BYPASS_ENABLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .lane_enable(b_en), .flit_in(b_in), .flit_in_valid(b_iv),
    .credit_out(b_cr), .flit_out(b_out), .flit_out_valid(b_ov), .flit_out_ready(b_rdy),
    .occupancy(b_occ), .overflow_err(b_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 2'b00; a_iv = 2'b00; a_rdy = 2'b00; a_in = '0;
    b_en = 1'b0;  b_iv = 1'b0;  b_rdy = 1'b0;  b_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    a_en = 2'b11;
    b_en = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_a", 128'({a_cr, a_ov, a_err, a_occ, a_out}), 128'(0));
      chk("idle_b", 128'({b_cr, b_ov, b_err, b_occ, b_out}), 128'(0));
    end

    // fill lane0 of dut_a with ready low
    for (int i = 1; i <= 4; i++) begin
      a_iv = 2'b01;
      a_in[32:0] = 33'h1_0000_0000 + 33'(i);
      tick();
      chk("fill_occ", 128'(a_occ[2:0]), 128'(i));
      chk("fill_cr", 128'(a_cr), 128'(0));
    end
    chk("fill_head", 128'({a_ov[0], a_out[32:0]}), 128'({1'b1, 33'h1_0000_0001}));

    // full, no pop: dropped
    a_in[32:0] = 33'h0AA;
    tick();
    chk("ovf_occ", 128'(a_occ[2:0]), 128'(4));
    chk("ovf_err", 128'(a_err[0]), 128'(1));
    chk("ovf_cr", 128'(a_cr[0]), 128'(0));
    a_iv = 2'b00;
    tick();
    chk("ovf_sticky", 128'(a_err[0]), 128'(1));

    // full with same-cycle pop: accepted
    a_iv = 2'b01; a_rdy = 2'b01; a_in[32:0] = 33'h0AB;
    #1;
    chk("fullpop_head", 128'(a_out[32:0]), 128'(33'h1_0000_0001));
    tick();
    chk("fullpop_occ", 128'(a_occ[2:0]), 128'(4));
    chk("fullpop_err", 128'(a_err[0]), 128'(1));
    chk("fullpop_cr", 128'(a_cr[0]), 128'(1));

    // drain in order
    a_iv = 2'b00;
    begin
      logic [32:0] exp_q [4];
      exp_q[0] = 33'h1_0000_0002; exp_q[1] = 33'h1_0000_0003;
      exp_q[2] = 33'h1_0000_0004; exp_q[3] = 33'h0AB;
      for (int i = 0; i < 4; i++) begin
        #1;
        chk("drain_dat", 128'({a_ov[0], a_out[32:0]}), 128'({1'b1, exp_q[i]}));
        tick();
        chk("drain_cr", 128'(a_cr[0]), 128'(1));
        chk("drain_occ", 128'(a_occ[2:0]), 128'(3 - i));
      end
    end
    a_rdy = 2'b00;
    tick();
    chk("drain_cr_end", 128'({a_cr[0], a_ov[0]}), 128'(0));

    // bypass on empty lane
    a_rdy = 2'b01; a_iv = 2'b01; a_in[32:0] = 33'h155;
    #1;
    chk("byp_comb", 128'({a_ov[0], a_out[32:0]}), 128'({1'b1, 33'h155}));
    tick();
    chk("byp_occ", 128'(a_occ[2:0]), 128'(0));
    chk("byp_cr", 128'(a_cr[0]), 128'(1));
    a_iv = 2'b00;
    tick();
    chk("byp_after", 128'({a_cr[0], a_ov[0]}), 128'(0));
    a_rdy = 2'b00;

    // bypass disabled: one-cycle path
    b_rdy = 1'b1; b_iv = 1'b1; b_in = 33'h155;
    #1;
    chk("nobyp_comb", 128'(b_ov), 128'(0));
    tick();
    chk("nobyp_occ", 128'(b_occ), 128'(1));
    b_iv = 1'b0;
    #1;
    chk("nobyp_dat", 128'({b_ov, b_out}), 128'({1'b1, 33'h155}));
    tick();
    chk("nobyp_cr", 128'({b_cr, b_occ}), 128'({1'b1, 2'd0}));

    // streaming through DEPTH=3 with one flit resident
    b_rdy = 1'b0; b_iv = 1'b1; b_in = 33'd100;
    tick();
    b_credits = 0;
    b_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_in = 33'(101 + i);
      #1;
      chk("strm_dat", 128'({b_ov, b_out}), 128'({1'b1, 33'(100 + i)}));
      tick();
      if (b_cr) b_credits++;
      chk("strm_occ", 128'(b_occ), 128'(1));
    end
    chk("strm_credits", 128'(b_credits), 128'(20));
    chk("strm_err", 128'(b_err), 128'(0));
    b_iv = 1'b0;
    #1;
    chk("strm_last", 128'(b_out), 128'(33'd120));
    tick();
    chk("strm_empty", 128'(b_occ), 128'(0));
    b_rdy = 1'b0;

    // two lanes: load both, flush lane0 while lane1 drains
    for (int k = 0; k < 3; k++) begin
      a_iv = 2'b11;
      a_in = {33'(32'h20 + k), 33'(32'h10 + k)};
      tick();
    end
    chk("two_occ", 128'(a_occ), 128'({3'd3, 3'd3}));
    a_iv = 2'b01; a_en = 2'b10; a_rdy = 2'b10;
    #1;
    chk("dis_vld", 128'(a_ov), 128'(2'b10));
    chk("dis_l1_dat", 128'(a_out[65:33]), 128'(33'h20));
    tick();
    chk("dis_occ", 128'(a_occ), 128'({3'd2, 3'd0}));
    chk("dis_cr", 128'(a_cr), 128'(2'b10));
    a_iv = 2'b00; a_en = 2'b11;
    #1;
    chk("reen_vld", 128'(a_ov), 128'(2'b10));
    chk("reen_l1_dat", 128'(a_out[65:33]), 128'(33'h21));
    tick();
    chk("reen_occ", 128'(a_occ), 128'({3'd1, 3'd0}));
    chk("reen_cr", 128'(a_cr), 128'(2'b10));
    chk("l1_err", 128'(a_err[1]), 128'(0));
    a_rdy = 2'b00;
    tick();
    chk("l1_hold", 128'({a_cr, a_ov}), 128'({2'b00, 2'b10}));

    // asynchronous reset mid-traffic
    a_iv = 2'b10; a_in[65:33] = 33'h1FF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a", 128'({a_cr, a_ov, a_err, a_occ, a_out}), 128'(0));
    chk("arst_b", 128'({b_cr, b_ov, b_err, b_occ, b_out}), 128'(0));
    a_iv = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
